// File: rtl/pcs_rx_pkg.sv
// Shared types and constants for the 10GBASE-R receive path.
package pcs_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2,
    HI_BER = 2'd3
  } rx_sync_state_t;

  localparam logic [1:0] SYNC_HDR_DATA = 2'b01;
  localparam logic [1:0] SYNC_HDR_CTRL = 2'b10;

endpackage

// File: rtl/rx_sync_ctrl_if.sv
// Link between block-lock FSM / gearbox and the sync controller.
interface rx_sync_ctrl_if #(
  parameter int HDR_WIDTH = 2
) ();

  logic [HDR_WIDTH-1:0] i_hdr;
  logic                 i_hdr_valid;
  logic                 i_block_lock;
  logic                 i_slip;
  logic                 o_slip;
  logic                 o_sync_restart;

  modport master (
    output i_hdr,
    output i_hdr_valid,
    output i_block_lock,
    output i_slip,
    input  o_slip,
    input  o_sync_restart
  );

  modport slave (
    input  i_hdr,
    input  i_hdr_valid,
    input  i_block_lock,
    input  i_slip,
    output o_slip,
    output o_sync_restart
  );

endinterface

// File: rtl/ber_monitor.sv
// Windowed invalid-header counter behind the high-BER decision.
module ber_monitor #(
  parameter int BER_WINDOW    = 19531,
  parameter int HI_BER_THRESH = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_beat,
  input  logic i_bad,
  output logic o_window_done,
  output logic o_thresh_hit
);

  localparam int WW = $clog2(BER_WINDOW);
  localparam int BW = $clog2(HI_BER_THRESH + 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(BER_WINDOW - 1);
  localparam logic [BW-1:0] THR      = BW'(HI_BER_THRESH);
  localparam logic [BW-1:0] THR_M1   = BW'(HI_BER_THRESH - 1);

  logic [WW-1:0] win_q, win_d;
  logic [BW-1:0] ber_q, ber_d;

  always_comb begin
    o_window_done = i_beat && (win_q == WIN_LAST);
    // count+1 view so a bad closing beat still lands in its window
    o_thresh_hit  = (ber_q == THR) ||
                    (i_bad && (ber_q == THR_M1));
    win_d = win_q;
    ber_d = ber_q;
    if (i_clear) begin
      win_d = '0;
      ber_d = '0;
    end else if (i_beat) begin
      if (o_window_done) begin
        win_d = '0;
        ber_d = '0;
      end else begin
        win_d = win_q + 1'b1;
        if (i_bad && (ber_q != THR))
          ber_d = ber_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      win_q <= '0;
      ber_q <= '0;
    end else begin
      win_q <= win_d;
      ber_q <= ber_d;
    end
  end

endmodule

// File: rtl/rx_sync_ctrl.sv
// 66b sync controller: paces gearbox slips, restarts failed hunts,
// and tracks high-BER once locked.
module rx_sync_ctrl
  import pcs_rx_pkg::*;
#(
  parameter int HDR_WIDTH     = 2,
  parameter int SLIP_HOLDOFF  = 4,
  parameter int MAX_SLIPS     = 66,
  parameter int BER_WINDOW    = 19531,
  parameter int HI_BER_THRESH = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_enable,
  rx_sync_ctrl_if.slave bus,
  output logic         o_rx_up,
  output logic         o_hi_ber,
  output logic [1:0]   o_state,
  output logic [7:0]   o_sync_fail_cnt,
  output logic [15:0]  o_err_cnt
);

  localparam int HW = $clog2(SLIP_HOLDOFF + 1);
  localparam int AW = $clog2(MAX_SLIPS + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(SLIP_HOLDOFF);
  localparam logic [AW-1:0] ATT_LAST  = AW'(MAX_SLIPS - 1);

  rx_sync_state_t state_q;
  logic [HW-1:0]  hold_q;
  logic [AW-1:0]  att_q;
  logic [7:0]     fail_q;
  logic [15:0]    err_q;
  logic           slip_q;
  logic           restart_q;

  logic [HDR_WIDTH-1:0] hdr;
  logic inv, fwd, hold_dec, in_lock;
  logic ber_clear, win_done, thresh_hit;

  always_comb begin
    hdr       = bus.i_hdr;
    inv       = bus.i_hdr_valid & ~^hdr;
    fwd       = bus.i_slip && (hold_q == '0);
    hold_dec  = bus.i_hdr_valid && (hold_q != '0);
    in_lock   = (state_q == LOCKED) || (state_q == HI_BER);
    ber_clear = !in_lock || !i_enable || !bus.i_block_lock;
  end

  ber_monitor #(
    .BER_WINDOW    (BER_WINDOW),
    .HI_BER_THRESH (HI_BER_THRESH)
  ) u_ber (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_clear       (ber_clear),
    .i_beat        (bus.i_hdr_valid),
    .i_bad         (inv),
    .o_window_done (win_done),
    .o_thresh_hit  (thresh_hit)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      att_q     <= '0;
      fail_q    <= '0;
      err_q     <= '0;
      slip_q    <= 1'b0;
      restart_q <= 1'b0;
    end else if (!i_enable) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      att_q     <= '0;
      fail_q    <= '0;
      err_q     <= '0;
      slip_q    <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      slip_q    <= 1'b0;
      restart_q <= 1'b0;
      unique case (state_q)
        IDLE: state_q <= HUNT;
        HUNT: begin
          // lock beats a same-cycle restart
          if (bus.i_block_lock) begin
            state_q <= LOCKED;
            att_q   <= '0;
            hold_q  <= '0;
          end else if (fwd) begin
            slip_q <= 1'b1;
            hold_q <= HOLD_LOAD;
            if (att_q == ATT_LAST) begin
              att_q     <= '0;
              restart_q <= 1'b1;
              if (fail_q != '1)
                fail_q <= fail_q + 1'b1;
            end else begin
              att_q <= att_q + 1'b1;
            end
          end else if (hold_dec) begin
            hold_q <= hold_q - 1'b1;
          end
        end
        default: begin
          if (fwd) begin
            slip_q <= 1'b1;
            hold_q <= HOLD_LOAD;
          end else if (hold_dec) begin
            hold_q <= hold_q - 1'b1;
          end
          if (inv && (err_q != '1))
            err_q <= err_q + 1'b1;
          if (!bus.i_block_lock)
            state_q <= HUNT;
          else if (state_q == LOCKED) begin
            if (thresh_hit)
              state_q <= HI_BER;
          end else if (win_done && !thresh_hit) begin
            state_q <= LOCKED;
          end
        end
      endcase
    end
  end

  assign bus.o_slip         = slip_q;
  assign bus.o_sync_restart = restart_q;
  assign o_rx_up            = (state_q == LOCKED);
  assign o_hi_ber           = (state_q == HI_BER);
  assign o_state            = state_q;
  assign o_sync_fail_cnt    = fail_q;
  assign o_err_cnt          = err_q;

endmodule

// File: doc/rx_sync_ctrl.md
# rx_sync_ctrl

Receive-side sync controller for the 10GBASE-R PCS. It sits between the 66b block-lock state machine and the RX gearbox, and paces slip requests toward the gearbox with a settle holdoff. It restarts the hunt when a full sweep of slip positions fails to lock, and runs the high-BER monitor once lock is achieved. Its link-status outputs feed the decoder and the management registers.

## Interface
- `HDR_WIDTH`, 2, sync header width
- `SLIP_HOLDOFF`, 4, header-valid beats to ignore slip requests after a forwarded slip
- `MAX_SLIPS`, 66, forwarded slips without lock before a hunt restart
- `BER_WINDOW`, 19531, header-valid beats per BER window (125 us at 156.25 MHz)
- `HI_BER_THRESH`, 16, invalid headers within one window that declare hi_ber
- `i_clk`  in  1  sole clock
- `i_reset`  in  1  asynchronous, active-high reset
- `i_enable`  in  1  level; low forces IDLE and clears all counters
- `i_hdr`  in  HDR_WIDTH  sync header from gearbox
- `i_hdr_valid`  in  1  `i_hdr` qualifier
- `i_block_lock`  in  1  lock status from block-lock FSM
- `i_slip`  in  1  slip request pulse from block-lock FSM
- `o_slip`  out  1  gated slip pulse to gearbox
- `o_sync_restart`  out  1  one-cycle pulse; resets block-lock FSM
- `o_rx_up`  out  1  locked and not hi_ber
- `o_hi_ber`  out  1  high-BER indication
- `o_state`  out  2  current state (IDLE=0, HUNT=1, LOCKED=2, HI_BER=3)
- `o_sync_fail_cnt`  out  8  saturating count of hunt restarts
- `o_err_cnt`  out  16  saturating count of invalid headers seen in LOCKED/HI_BER

## Operation
- Invalid header: `i_hdr_valid & ~^i_hdr`, i.e. a header of 00 or 11.
- **IDLE**
  - All counters and pulses are held at 0.
  - Moves to HUNT on the first cycle `i_enable`=1.
- **HUNT**
  - An `i_slip` outside holdoff is forwarded as `o_slip`, loads the holdoff counter with SLIP_HOLDOFF, and increments the attempt counter.
  - The holdoff counter decrements on each `i_hdr_valid` until it reaches 0.
  - `i_slip` during holdoff is dropped and does not count as an attempt.
  - When the attempt counter reaches MAX_SLIPS:
    - `o_sync_restart` pulses and the attempt counter clears.
    - `o_sync_fail_cnt` increments, saturating at 255.
    - The state stays HUNT.
  - `i_block_lock`=1 moves to LOCKED and clears the attempt counter and the holdoff counter.
- **LOCKED**
  - The window counter counts `i_hdr_valid` beats from 0 to BER_WINDOW-1, then wraps.
  - The BER counter counts invalid headers, saturating at HI_BER_THRESH.
  - On the beat that closes a window, the BER counter clears.
  - Reaching HI_BER_THRESH within a window moves to HI_BER.
- **HI_BER**
  - Windowing continues.
  - A window that closes with a count below HI_BER_THRESH returns to LOCKED.
  - A window that reaches the threshold keeps HI_BER.
- **LOCKED / HI_BER common rules**
  - `i_block_lock`=0 moves to HUNT and clears the window and BER counters.
  - `i_slip` is forwarded as `o_slip`. It normally coincides with the lock drop, and it starts the holdoff.
  - `o_err_cnt` increments on every invalid header, saturating at 65535.
- **Priority and boundary rules**
  - Priority order: `i_enable`=0, then lock drop, then the BER transition.
  - An invalid header on the window-closing beat counts toward the closing window, so the compare uses count+1.
  - A restart and a lock on the same cycle: lock wins and no restart pulse is issued.
  - `i_enable` falling mid-state goes to IDLE next cycle and clears everything, including `o_err_cnt` and `o_sync_fail_cnt`.

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0.
- `o_slip` is registered and asserts the cycle after `i_slip`. It is never high on two consecutive cycles.
- `o_sync_restart` is a registered one-cycle pulse, issued in the cycle after the MAX_SLIPS-th forwarded slip.
- `o_rx_up`, `o_hi_ber` and `o_state` are decoded from the state register only, with no combinational path from inputs. They change one cycle after the triggering input.
- Counter widths:
  - Window counter: `$clog2(BER_WINDOW)`.
  - BER counter: `$clog2(HI_BER_THRESH+1)`.
  - Attempt counter: `$clog2(MAX_SLIPS+1)`.
  - Holdoff counter: `$clog2(SLIP_HOLDOFF+1)`.
  - All counters are unsigned; none wraps except the window counter.

## Structure
- Shared package `pcs_rx_pkg` holds:
  - the `rx_sync_state_t` enum (IDLE/HUNT/LOCKED/HI_BER, 2 bits);
  - the `SYNC_HDR_DATA`=2'b01 and `SYNC_HDR_CTRL`=2'b10 constants.
- Sub-module `ber_monitor` contains the window counter, the saturating BER counter, `o_window_done` and `o_thresh_hit`. The top FSM instantiates it with a clear input driven on lock loss and IDLE.

## Test plan
- Reset asserted mid-HUNT with `o_slip` pending -> all outputs 0 immediately; state IDLE after release.
- HUNT with `i_slip` pulsed on every `i_hdr_valid`, SLIP_HOLDOFF=4 -> `o_slip` on every 5th header beat only; attempt counter increments once per forwarded slip.
- HUNT with 66 forwarded slips and no lock -> one `o_sync_restart` pulse after the 66th; `o_sync_fail_cnt`=1; state stays HUNT.
- LOCKED with 15 invalid headers in one window -> stays LOCKED, `o_rx_up`=1, `o_err_cnt`=15. With 16 invalid headers -> HI_BER, `o_rx_up`=0.
- HI_BER followed by a clean window of 19531 beats -> LOCKED on the beat after window close. 16th invalid header on the closing beat -> stays HI_BER.
- `i_block_lock` drop while in HI_BER, with a simultaneous `i_slip` -> state HUNT, `o_hi_ber`=0, `o_slip` one cycle later, holdoff started.
